// File: rtl/fft_pkg.sv
// fft_pkg: shared state encoding, FFT constants and index helper for fft8_stream
package fft_pkg;
  typedef enum logic [2:0] {LOAD, ST0, ST1, ST2, OUT} state_e;
  localparam int TW_C = 181;
  localparam int TW_SH = 8;
  localparam int N = 8;
  localparam int LOG2N = 3;
  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] n);
    return {n[0], n[1], n[2]};
  endfunction
endpackage

// File: rtl/fft_bfly.sv
// fft_bfly: combinational radix-2 butterfly with W8^0..W8^3 twiddle and optional halving
module fft_bfly
  import fft_pkg::*;
#(
  parameter int OUT_W = 12
) (
  input  logic signed [OUT_W-1:0] ur_i,
  input  logic signed [OUT_W-1:0] ui_i,
  input  logic signed [OUT_W-1:0] vr_i,
  input  logic signed [OUT_W-1:0] vi_i,
  input  logic        [1:0]       tw_i,
  input  logic                    scale_i,
  output logic signed [OUT_W-1:0] ur_o,
  output logic signed [OUT_W-1:0] ui_o,
  output logic signed [OUT_W-1:0] vr_o,
  output logic signed [OUT_W-1:0] vi_o
);
  localparam int W1 = OUT_W + 1;
  localparam int WM = OUT_W + 9;
  logic signed [W1-1:0] a, b, s, d, ts, td, tn, wr, wi, sr, si, dr, di;
  logic signed [WM-1:0] ps, pd;
  // 181/256 approximates 1/sqrt2; floor shifts keep the odd twiddles bit-exact
  always_comb begin
    a = W1'(vr_i);
    b = W1'(vi_i);
    s = a + b;
    d = b - a;
    ps = WM'(s) * WM'(TW_C);
    pd = WM'(d) * WM'(TW_C);
    ts = W1'(ps >>> TW_SH);
    td = W1'(pd >>> TW_SH);
    tn = W1'((-ps) >>> TW_SH);
    wr = tw_i == 2'd0 ? a : tw_i == 2'd1 ? ts : tw_i == 2'd2 ? b : td;
    wi = tw_i == 2'd0 ? b : tw_i == 2'd1 ? td : tw_i == 2'd2 ? -a : tn;
    sr = W1'(ur_i) + wr;
    si = W1'(ui_i) + wi;
    dr = W1'(ur_i) - wr;
    di = W1'(ui_i) - wi;
    ur_o = OUT_W'(scale_i ? sr >>> 1 : sr);
    ui_o = OUT_W'(scale_i ? si >>> 1 : si);
    vr_o = OUT_W'(scale_i ? dr >>> 1 : dr);
    vi_o = OUT_W'(scale_i ? di >>> 1 : di);
  end
endmodule

// File: rtl/fft8_stream.sv
// fft8_stream: streaming 8-point radix-2 DIT FFT of real samples, valid/ready in and out
module fft8_stream
  import fft_pkg::*;
#(
  parameter int IN_W = 8,
  parameter int OUT_W = IN_W + 4,
  parameter int SIGNED_IN = 0,
  parameter int SCALE = 0,
  parameter int FULL_OUT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic        [IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_re,
  output logic signed [OUT_W-1:0] out_im,
  output logic        [2:0]       out_idx,
  output logic                    out_last
);
  localparam logic [LOG2N-1:0] LAST = FULL_OUT != 0 ? 3'd7 : 3'd4;
  state_e state_q;
  logic [LOG2N-1:0] n_q, k_q;
  logic in_ready_q, out_valid_q, out_last_q;
  logic signed [OUT_W-1:0] re_q [N];
  logic signed [OUT_W-1:0] im_q [N];
  logic signed [OUT_W-1:0] out_re_q, out_im_q, sample;
  logic [LOG2N-1:0] u_idx [4];
  logic [LOG2N-1:0] v_idx [4];
  logic [1:0] tw [4];
  logic signed [OUT_W-1:0] bur [4];
  logic signed [OUT_W-1:0] bui [4];
  logic signed [OUT_W-1:0] bvr [4];
  logic signed [OUT_W-1:0] bvi [4];
  assign sample = {{(OUT_W-IN_W){(SIGNED_IN != 0) && in_data[IN_W-1]}}, in_data};
  // Butterfly b of each stage: stage s pairs elements 2^s apart inside groups of 2^(s+1)
  for (genvar b = 0; b < 4; b++) begin : g_bf
    localparam logic [2:0] U1 = 3'(4 * (b / 2) + b % 2);
    assign u_idx[b] = state_q == ST0 ? 3'(2 * b) : state_q == ST1 ? U1 : 3'(b);
    assign v_idx[b] = state_q == ST0 ? 3'(2 * b + 1) : state_q == ST1 ? 3'(U1 + 2) : 3'(b + 4);
    assign tw[b] = state_q == ST0 ? 2'd0 : state_q == ST1 ? 2'(2 * (b % 2)) : 2'(b);
    fft_bfly #(.OUT_W(OUT_W)) u_bfly (
      .ur_i(re_q[u_idx[b]]), .ui_i(im_q[u_idx[b]]),
      .vr_i(re_q[v_idx[b]]), .vi_i(im_q[v_idx[b]]),
      .tw_i(tw[b]), .scale_i(SCALE != 0),
      .ur_o(bur[b]), .ui_o(bui[b]), .vr_o(bvr[b]), .vi_o(bvi[b])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      n_q <= '0;
      k_q <= '0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q <= 1'b0;
      out_re_q <= '0;
      out_im_q <= '0;
    end else begin
      case (state_q)
        LOAD: if (in_valid && in_ready_q) begin
          re_q[bitrev3(n_q)] <= sample;
          im_q[bitrev3(n_q)] <= '0;
          n_q <= n_q + 3'd1;
          if (n_q == 3'd7) begin
            state_q <= ST0;
            in_ready_q <= 1'b0;
          end
        end
        ST0, ST1, ST2: begin
          for (int b = 0; b < 4; b++) begin
            re_q[u_idx[b]] <= bur[b];
            im_q[u_idx[b]] <= bui[b];
            re_q[v_idx[b]] <= bvr[b];
            im_q[v_idx[b]] <= bvi[b];
          end
          state_q <= state_q == ST0 ? ST1 : state_q == ST1 ? ST2 : OUT;
          // bin 0 is taken straight from the last stage so it is valid on entry to OUT
          if (state_q == ST2) begin
            out_valid_q <= 1'b1;
            out_re_q <= bur[0];
            out_im_q <= bui[0];
            out_last_q <= 1'b0;
            k_q <= '0;
          end
        end
        OUT: if (out_ready) begin
          if (out_last_q) begin
            state_q <= LOAD;
            out_valid_q <= 1'b0;
            out_last_q <= 1'b0;
            k_q <= '0;
            in_ready_q <= 1'b1;
          end else begin
            k_q <= k_q + 3'd1;
            out_re_q <= re_q[k_q + 3'd1];
            out_im_q <= im_q[k_q + 3'd1];
            out_last_q <= (k_q + 3'd1) == LAST;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last = out_last_q;
  assign out_re = out_re_q;
  assign out_im = out_im_q;
  assign out_idx = k_q;
endmodule
